sdram_frame_sched: RTL and testbench

//  Burst scheduler between the UART write FIFO, the VGA read FIFO and the SDRAM controller (sclk = 100 MHz domain).

---
 rtl/sdram_frame_sched.sv | 160 ++++++++++++++++
 tb/tb_sdram_frame_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_sched.sv
// Burst scheduler sitting between the UART write FIFO, the VGA read FIFO and the SDRAM controller.
// It arbitrates refresh, write and read bursts, and ping-pongs between two frame buffers.
module sdram_frame_sched #(
  parameter int unsigned        ADDR_W      = 24,
  parameter int unsigned        BURST_LEN   = 8,
  parameter int unsigned        FRAME_WORDS = 384000,
  parameter logic [ADDR_W-1:0]  FB1_BASE    = ADDR_W'(24'h800000),
  parameter int unsigned        CNT_W       = 10,
  parameter int unsigned        RFIFO_DEPTH = 512,
  parameter int unsigned        RFIFO_LOW   = 256
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              init_done,
  input  logic              aref_req,
  output logic              aref_en,
  input  logic              aref_done,
  input  logic [CNT_W-1:0]  wfifo_cnt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_done,
  input  logic [CNT_W-1:0]  rfifo_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_ready
);

  localparam int unsigned     OfsW     = $clog2(FRAME_WORDS + 1);
  localparam logic [OfsW-1:0] OfsStep  = OfsW'(BURST_LEN);
  localparam logic [OfsW-1:0] OfsLast  = OfsW'(FRAME_WORDS - BURST_LEN);
  localparam logic [CNT_W-1:0] CntBurst = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CntLow   = CNT_W'(RFIFO_LOW);
  localparam logic [CNT_W-1:0] CntRoom  = CNT_W'(RFIFO_DEPTH - BURST_LEN);

  typedef enum logic [2:0] {StIdle, StArb, StAref, StWrite, StRead} state_e;

  state_e          state_q;
  logic            aref_en_q, wr_en_q, rd_en_q;
  logic            rd_ready_q, rd_ready_d;
  logic [OfsW-1:0] wr_ofs_q, wr_ofs_d;
  logic [OfsW-1:0] rd_ofs_q, rd_ofs_d;
  logic            wr_buf_q, wr_buf_d;
  logic            rd_buf_q, rd_buf_d;
  logic            frame_ok_q, frame_ok_d;
  logic            wr_step, rd_step, wr_wrap, rd_wrap;

  // Done pulses only count while the matching burst is in flight.
  always_comb begin
    wr_step    = (state_q == StWrite) && wr_done;
    rd_step    = (state_q == StRead) && rd_done;
    wr_wrap    = wr_step && (wr_ofs_q == OfsLast);
    rd_wrap    = rd_step && (rd_ofs_q == OfsLast);
    wr_ofs_d   = wr_ofs_q;
    rd_ofs_d   = rd_ofs_q;
    wr_buf_d   = wr_buf_q;
    rd_buf_d   = rd_buf_q;
    frame_ok_d = frame_ok_q;
    if (wr_step) begin
      wr_ofs_d = wr_wrap ? '0 : wr_ofs_q + OfsStep;
    end
    if (wr_wrap) begin
      wr_buf_d   = ~wr_buf_q;
      frame_ok_d = 1'b1;
      if (!frame_ok_q) begin
        rd_buf_d = wr_buf_q;
      end
    end
    if (rd_step) begin
      rd_ofs_d = rd_wrap ? '0 : rd_ofs_q + OfsStep;
    end
    // Follow the most recently completed frame, including one finishing this very cycle.
    if (rd_wrap) begin
      rd_buf_d = ~wr_buf_d;
    end
    rd_ready_d = rd_ready_q | (frame_ok_q & (rfifo_cnt >= CntLow));
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      wr_ofs_q   <= '0;
      rd_ofs_q   <= '0;
      wr_buf_q   <= 1'b0;
      rd_buf_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      rd_ready_q <= 1'b0;
    end else begin
      wr_ofs_q   <= wr_ofs_d;
      rd_ofs_q   <= rd_ofs_d;
      wr_buf_q   <= wr_buf_d;
      rd_buf_q   <= rd_buf_d;
      frame_ok_q <= frame_ok_d;
      rd_ready_q <= rd_ready_d;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q   <= StIdle;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (init_done) begin
            state_q <= StArb;
          end
        end
        StArb: begin
          if (aref_req) begin
            state_q   <= StAref;
            aref_en_q <= 1'b1;
          end else if (frame_ok_q && (rfifo_cnt < CntLow)) begin
            state_q <= StRead;
            rd_en_q <= 1'b1;
          end else if (wfifo_cnt >= CntBurst) begin
            state_q <= StWrite;
            wr_en_q <= 1'b1;
          end else if (frame_ok_q && (rfifo_cnt <= CntRoom)) begin
            state_q <= StRead;
            rd_en_q <= 1'b1;
          end
        end
        StAref: begin
          if (aref_done) begin
            state_q   <= StArb;
            aref_en_q <= 1'b0;
          end
        end
        StWrite: begin
          if (wr_done) begin
            state_q <= StArb;
            wr_en_q <= 1'b0;
          end
        end
        StRead: begin
          if (rd_done) begin
            state_q <= StArb;
            rd_en_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          aref_en_q <= 1'b0;
          wr_en_q   <= 1'b0;
          rd_en_q   <= 1'b0;
        end
      endcase
    end
  end

  assign aref_en  = aref_en_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign rd_ready = rd_ready_q;
  assign wr_addr  = (wr_buf_q ? FB1_BASE : '0) + ADDR_W'(wr_ofs_q);
  assign rd_addr  = (rd_buf_q ? FB1_BASE : '0) + ADDR_W'(rd_ofs_q);

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Directed bench for sdram_frame_sched with a shortened frame (8 bursts) so that
// several buffer swaps fit in a short run.
module tb_sdram_frame_sched;

  localparam logic [23:0] Fb1 = 24'h800000;

  logic        sclk = 1'b0;
  logic        s_rst, init_done, aref_req, aref_done, wr_done, rd_done;
  logic [9:0]  wfifo_cnt, rfifo_cnt;
  logic        aref_en, wr_en, rd_en, rd_ready;
  logic [23:0] wr_addr, rd_addr;
  int          n_checks = 0;
  int          n_pass   = 0;

  sdram_frame_sched #(
    .FRAME_WORDS(64)
  ) u_dut (
    .sclk      (sclk),
    .s_rst     (s_rst),
    .init_done (init_done),
    .aref_req  (aref_req),
    .aref_en   (aref_en),
    .aref_done (aref_done),
    .wfifo_cnt (wfifo_cnt),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_done   (wr_done),
    .rfifo_cnt (rfifo_cnt),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_done   (rd_done),
    .rd_ready  (rd_ready)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic en_of(input int which);
    case (which)
      0:       return aref_en;
      1:       return wr_en;
      default: return rd_en;
    endcase
  endfunction

  // which: 0 = refresh, 1 = write, 2 = read. The burst must start exactly one cycle after entry.
  task automatic run_burst(input string tag, input int which, input logic [23:0] exp_addr,
                           input int lat, input bit raise_aref);
    int n = 0;
    int wait_cycles = lat;
    while (en_of(which) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " start"}, 32'(n), 32'd1);
    if (which == 1) check({tag, " addr"}, 32'(wr_addr), 32'(exp_addr));
    if (which == 2) check({tag, " addr"}, 32'(rd_addr), 32'(exp_addr));
    if (raise_aref) begin
      tick();
      aref_req = 1'b1;
      wait_cycles--;
    end
    repeat (wait_cycles) tick();
    check({tag, " held"}, 32'(en_of(which)), 32'd1);
    if (raise_aref) check({tag, " no preempt"}, 32'(aref_en), 32'd0);
    case (which)
      0: begin aref_done = 1'b1; aref_req = 1'b0; end
      1: wr_done = 1'b1;
      default: rd_done = 1'b1;
    endcase
    tick();
    aref_done = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    check({tag, " drop"}, 32'(en_of(which)), 32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    s_rst = 1'b1; init_done = 1'b0; aref_req = 1'b0; aref_done = 1'b0;
    wr_done = 1'b0; rd_done = 1'b0; wfifo_cnt = '0; rfifo_cnt = '0;

    // T1: reset, then no activity until init_done even with a refresh pending
    repeat (3) tick();
    check("rst aref_en", 32'(aref_en), 32'd0);
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst rd_en", 32'(rd_en), 32'd0);
    check("rst rd_ready", 32'(rd_ready), 32'd0);
    check("rst wr_addr", 32'(wr_addr), 32'd0);
    check("rst rd_addr", 32'(rd_addr), 32'd0);
    s_rst = 1'b0;
    aref_req = 1'b1;
    repeat (3) tick();
    check("idle aref gated", 32'(aref_en), 32'd0);
    aref_req = 1'b0;
    init_done = 1'b1;
    repeat (3) tick();
    check("arb no wr", 32'(wr_en), 32'd0);
    check("arb no rd", 32'(rd_en), 32'd0);
    check("arb no aref", 32'(aref_en), 32'd0);

    // T2: first frame of writes into buffer 0; no reads despite an empty read FIFO
    wfifo_cnt = 10'd8;
    for (int i = 0; i < 8; i++) begin
      run_burst("wr f1", 1, 24'(i * 8), 4, 1'b0);
      check("f1 no rd", 32'(rd_en), 32'd0);
      check("f1 no ready", 32'(rd_ready), 32'd0);
    end
    run_burst("rd first", 2, 24'd0, 2, 1'b0);
    rfifo_cnt = 10'd600;
    run_burst("wr fb1", 1, Fb1, 4, 1'b0);

    // T3: refresh beats urgent read beats write
    aref_req  = 1'b1;
    rfifo_cnt = 10'd100;
    run_burst("pri aref", 0, 24'd0, 3, 1'b0);
    run_burst("pri rd", 2, 24'd8, 2, 1'b0);
    rfifo_cnt = 10'd600;
    run_burst("pri wr", 1, Fb1 + 24'd8, 4, 1'b0);

    // T4: refresh raised mid-write waits for the burst to finish
    run_burst("np wr", 1, Fb1 + 24'd16, 4, 1'b1);
    run_burst("np aref", 0, 24'd0, 3, 1'b0);

    // T5: second frame completes, then reads finish buffer 0 and switch to buffer 1
    for (int i = 3; i < 8; i++) run_burst("wr f2", 1, Fb1 + 24'(i * 8), 4, 1'b0);
    rfifo_cnt = 10'd100;
    for (int i = 2; i < 8; i++) run_burst("rd f1", 2, 24'(i * 8), 2, 1'b0);
    tick();
    check("pp rd_en", 32'(rd_en), 32'd1);
    check("pp rd_addr", 32'(rd_addr), 32'(Fb1));
    check("ready sticky", 32'(rd_ready), 32'd1);

    // T6: reset during a read burst, then rd_ready on the low-watermark boundary
    s_rst = 1'b1;
    tick();
    check("mrst rd_en", 32'(rd_en), 32'd0);
    check("mrst rd_ready", 32'(rd_ready), 32'd0);
    check("mrst wr_addr", 32'(wr_addr), 32'd0);
    check("mrst rd_addr", 32'(rd_addr), 32'd0);
    s_rst = 1'b0;
    rfifo_cnt = 10'd255;
    tick();
    for (int i = 0; i < 8; i++) begin
      run_burst("wr f3", 1, 24'(i * 8), 4, 1'b0);
      check("f3 no ready", 32'(rd_ready), 32'd0);
    end
    rfifo_cnt = 10'd256;
    tick();
    check("low ready", 32'(rd_ready), 32'd1);
    check("low wr_en", 32'(wr_en), 32'd1);
    check("low wr_addr", 32'(wr_addr), 32'(Fb1));
    rfifo_cnt = 10'd0;
    repeat (4) tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("low wr drop", 32'(wr_en), 32'd0);
    check("ready holds", 32'(rd_ready), 32'd1);
    wfifo_cnt = 10'd7;
    rfifo_cnt = 10'd505;
    repeat (3) tick();
    check("full no rd", 32'(rd_en), 32'd0);
    check("short no wr", 32'(wr_en), 32'd0);
    rfifo_cnt = 10'd504;
    run_burst("rd room", 2, 24'd0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
